// File: rtl/label_merger_pkg.sv
// Shared types and constants for the label equivalence (union-find) merger.
`default_nettype none
package label_merger_pkg;

  localparam int DEFAULT_LABEL_WIDTH = 8;

  typedef logic [DEFAULT_LABEL_WIDTH-1:0] label_t;

  typedef struct packed {
    label_t a;
    label_t b;
  } merge_req_t;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    DRAIN   = 2'd1,
    FLATTEN = 2'd2,
    DONE    = 2'd3
  } top_state_t;

  typedef enum logic [1:0] {
    M_IDLE = 2'd0,
    FIND_A = 2'd1,
    FIND_B = 2'd2,
    LINK   = 2'd3
  } merge_state_t;

  localparam label_t BG_LABEL = '0;

endpackage
`default_nettype wire

// File: rtl/label_merge_fifo.sv
// Synchronous FIFO buffering merge requests; DEPTH must be a power of two (>= 2).
`default_nettype none
module label_merge_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage needs no reset: occupancy alone decides what is readable.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/label_merger.sv
// Per-frame label equivalence table: buffered find/link merges, single-pass
// ascending flatten at frame end, and a registered resolved-root lookup.
`default_nettype none
module label_merger
  import label_merger_pkg::*;
#(
  parameter int LABEL_WIDTH      = DEFAULT_LABEL_WIDTH,
  parameter int MERGE_FIFO_DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   last_in_frame,
  input  logic                   new_label_valid,
  input  logic [LABEL_WIDTH-1:0] new_label_value,
  input  logic                   merge_labels,
  input  logic [LABEL_WIDTH-1:0] merge_a,
  input  logic [LABEL_WIDTH-1:0] merge_b,
  input  logic                   lookup_en,
  input  logic [LABEL_WIDTH-1:0] lookup_label,
  output logic                   lookup_valid,
  output logic [LABEL_WIDTH-1:0] lookup_root,
  output logic [LABEL_WIDTH-1:0] max_label,
  output logic                   busy,
  output logic                   resolve_done,
  output logic                   overflow
);

  localparam int NUM_LABELS = 2**LABEL_WIDTH;
  typedef logic [LABEL_WIDTH-1:0] lbl_t;
  localparam lbl_t BG = LABEL_WIDTH'(BG_LABEL);

  top_state_t   state, state_next;
  merge_state_t mstate, mstate_next;

  lbl_t parent [NUM_LABELS];
  lbl_t walk, walk_next;
  lbl_t pend_b, pend_b_next;
  lbl_t root_a, root_a_next;
  lbl_t flat_idx;
  lbl_t link_idx, link_val;
  logic link_we;

  logic                     fifo_pop, fifo_full, fifo_empty;
  logic [2*LABEL_WIDTH-1:0] fifo_data;

  logic evt_window, nl_acc, mg_acc, nl_write, restart, drop, merge_run;

  assign evt_window = enable && (state != FLATTEN);
  assign nl_acc     = evt_window && new_label_valid;
  assign mg_acc     = evt_window && merge_labels;
  assign nl_write   = nl_acc && (new_label_value != BG);
  assign restart    = (state == DONE) && (nl_acc || mg_acc);
  assign drop       = (enable && (state == FLATTEN) && (new_label_valid || merge_labels))
                   || (nl_acc && (new_label_value == BG))
                   || (mg_acc && fifo_full);
  assign merge_run  = (state == COLLECT) || (state == DRAIN);
  assign busy       = (state == DRAIN) || (state == FLATTEN);

  label_merge_fifo #(
    .WIDTH (2*LABEL_WIDTH),
    .DEPTH (MERGE_FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (mg_acc),
    .push_data ({merge_a, merge_b}),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Find/link: walk each operand to its root, then hang the larger root under the smaller.
  always_comb begin
    mstate_next = mstate;
    walk_next   = walk;
    pend_b_next = pend_b;
    root_a_next = root_a;
    fifo_pop    = 1'b0;
    link_we     = 1'b0;
    link_idx    = (root_a > walk) ? root_a : walk;
    link_val    = (root_a > walk) ? walk : root_a;
    case (mstate)
      M_IDLE: begin
        if (merge_run && !fifo_empty) begin
          fifo_pop    = 1'b1;
          walk_next   = fifo_data[2*LABEL_WIDTH-1:LABEL_WIDTH];
          pend_b_next = fifo_data[LABEL_WIDTH-1:0];
          mstate_next = FIND_A;
        end
      end
      FIND_A: begin
        if (parent[walk] == walk) begin
          root_a_next = walk;
          walk_next   = pend_b;
          mstate_next = FIND_B;
        end else begin
          walk_next = parent[walk];
        end
      end
      FIND_B: begin
        if (parent[walk] == walk) mstate_next = LINK;
        else                      walk_next   = parent[walk];
      end
      LINK: begin
        link_we     = (root_a != walk);
        mstate_next = M_IDLE;
      end
      default: mstate_next = M_IDLE;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      COLLECT: if (enable && last_in_frame) state_next = DRAIN;
      DRAIN: begin
        // A merge arriving this very cycle must still be drained before flattening.
        if (fifo_empty && !mg_acc && (mstate == M_IDLE))
          state_next = (max_label == BG) ? DONE : FLATTEN;
      end
      FLATTEN: if (flat_idx >= max_label) state_next = DONE;
      DONE:    if (restart) state_next = COLLECT;
      default: state_next = COLLECT;
    endcase
  end

  // New-label and link writes never collide: a new label exceeds every linked index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_LABELS; k++) parent[k] <= '0;
    end else begin
      if (state == FLATTEN) parent[flat_idx] <= parent[parent[flat_idx]];
      if (link_we)          parent[link_idx] <= link_val;
      if (nl_write)         parent[new_label_value] <= new_label_value;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= COLLECT;
      mstate       <= M_IDLE;
      walk         <= '0;
      pend_b       <= '0;
      root_a       <= '0;
      flat_idx     <= '0;
      max_label    <= '0;
      overflow     <= 1'b0;
      resolve_done <= 1'b0;
      lookup_valid <= 1'b0;
      lookup_root  <= '0;
    end else begin
      state  <= state_next;
      mstate <= mstate_next;
      walk   <= walk_next;
      pend_b <= pend_b_next;
      root_a <= root_a_next;
      if (state_next == FLATTEN && state != FLATTEN) flat_idx <= lbl_t'(1);
      else if (state == FLATTEN)                     flat_idx <= flat_idx + 1'b1;
      if (nl_write)     max_label <= new_label_value;
      else if (restart) max_label <= BG;
      overflow     <= (overflow && !restart) || drop;
      resolve_done <= (state_next == DONE) && (state != DONE);
      lookup_valid <= lookup_en && (state == DONE);
      if (lookup_en && (state == DONE) && (lookup_label != BG) && (lookup_label <= max_label))
        lookup_root <= parent[lookup_label];
      else
        lookup_root <= BG;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_label_merger.sv
// Scoreboarded bench for label_merger against a component-minimum reference model.
`default_nettype none
module tb_label_merger;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         enable = 1'b0, last_in_frame = 1'b0, new_label_valid = 1'b0;
  logic         merge_labels = 1'b0, lookup_en = 1'b0;
  logic [W-1:0] new_label_value = '0, merge_a = '0, merge_b = '0, lookup_label = '0;
  logic         lookup_valid, busy, resolve_done, overflow;
  logic [W-1:0] lookup_root, max_label;

  label_merger #(.LABEL_WIDTH(W), .MERGE_FIFO_DEPTH(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .enable          (enable),
    .last_in_frame   (last_in_frame),
    .new_label_valid (new_label_valid),
    .new_label_value (new_label_value),
    .merge_labels    (merge_labels),
    .merge_a         (merge_a),
    .merge_b         (merge_b),
    .lookup_en       (lookup_en),
    .lookup_label    (lookup_label),
    .lookup_valid    (lookup_valid),
    .lookup_root     (lookup_root),
    .max_label       (max_label),
    .busy            (busy),
    .resolve_done    (resolve_done),
    .overflow        (overflow)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  int exp_q[$];
  int lab_q[$];
  int comp[256];   // reference: every label's root is the smallest label of its component

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && lookup_valid) begin
      if (exp_q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL lookup_unexpected: got valid with root %0d, expected no response", lookup_root);
      end else begin
        int e, l;
        e = exp_q.pop_front();
        l = lab_q.pop_front();
        chk($sformatf("lookup[%0d]", l), int'(lookup_root), e);
      end
    end
  end

  function automatic void begin_frame();
    for (int x = 0; x < 256; x++) comp[x] = 0;
  endfunction

  function automatic void model_merge(input int a, input int b);
    int ca, cb, m;
    ca = comp[a];
    cb = comp[b];
    m  = (ca < cb) ? ca : cb;
    for (int x = 1; x < 256; x++)
      if (comp[x] == ca || comp[x] == cb) comp[x] = m;
  endfunction

  task automatic idle(input int k);
    repeat (k) begin @(posedge clk); #1; end
  endtask

  task automatic cyc(input bit nl, input int v, input bit mg, input int a, input int b,
                     input bit lif, input bit en, input bit lk, input int lkl);
    enable = en; new_label_valid = nl; new_label_value = W'(v);
    merge_labels = mg; merge_a = W'(a); merge_b = W'(b);
    last_in_frame = lif; lookup_en = lk; lookup_label = W'(lkl);
    @(posedge clk); #1;
    enable = 0; new_label_valid = 0; merge_labels = 0; last_in_frame = 0; lookup_en = 0;
  endtask

  task automatic alloc(input int v, input bit mg, input int a, input int b, input bit lk);
    cyc(1'b1, v, mg, a, b, 1'b0, 1'b1, lk, $urandom_range(0, 255));
    comp[v] = v;
    if (mg) model_merge(a, b);
  endtask

  task automatic merge(input int a, input int b, input int cool);
    cyc(1'b0, 0, 1'b1, a, b, 1'b0, 1'b1, 1'b0, 0);
    model_merge(a, b);
    idle(cool);
  endtask

  task automatic finish_frame(input int n, input bit exp_ovf);
    int waited;
    waited = 0;
    cyc(1'b0, 0, 1'b0, 0, 0, 1'b1, 1'b1, 1'b0, 0);
    while (resolve_done !== 1'b1 && waited < 1000) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("resolve_done_seen", int'(resolve_done), 1);
    chk("max_label", int'(max_label), n);
    chk("busy_in_done", int'(busy), 0);
    chk("overflow_in_done", int'(overflow), int'(exp_ovf));
    for (int x = 0; x <= n + 2; x++) begin
      lab_q.push_back(x);
      exp_q.push_back((x >= 1 && x <= n) ? comp[x] : 0);
      cyc(1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, x);
      if (x == 0) chk("resolve_done_pulse", int'(resolve_done), 0);
    end
    idle(3);
    chk("lookups_answered", exp_q.size(), 0);
    exp_q.delete();
    lab_q.delete();
  endtask

  task automatic random_frame();
    int n, cool, a, b;
    bit mg, lk;
    n    = $urandom_range(1, 12);
    cool = 2 * n + 8;
    begin_frame();
    for (int v = 1; v <= n; v++) begin
      mg = (v > 1) && ($urandom_range(0, 1) == 1);
      lk = (v > 1) && ($urandom_range(0, 3) == 0);
      a  = $urandom_range(1, v);
      b  = $urandom_range(1, v);
      alloc(v, mg, a, b, lk);
      if (v == 1) chk("overflow_cleared", int'(overflow), 0);
      if (mg) idle(cool);
      if ($urandom_range(0, 3) == 0)
        cyc(1'b1, $urandom_range(0, 255), 1'b1, $urandom_range(0, 255),
            $urandom_range(0, 255), 1'b1, 1'b0, 1'b0, 0);
      if ($urandom_range(0, 3) == 0) merge($urandom_range(1, v), $urandom_range(1, v), cool);
    end
    finish_frame(n, 1'b0);
  endtask

  initial begin
    idle(2);
    chk("rst_max_label", int'(max_label), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_resolve_done", int'(resolve_done), 0);
    chk("rst_lookup_valid", int'(lookup_valid), 0);
    rst = 1'b0;
    idle(1);

    // Plain labels, no merges.
    begin_frame();
    for (int v = 1; v <= 3; v++) alloc(v, 1'b0, 0, 0, 1'b0);
    finish_frame(3, 1'b0);

    // Chain of merges collapsing onto label 1.
    begin_frame();
    for (int v = 1; v <= 4; v++) alloc(v, 1'b0, 0, 0, 1'b0);
    merge(3, 4, 16); merge(2, 3, 16); merge(1, 2, 16);
    finish_frame(4, 1'b0);

    // Distinct roots linked through a shared label.
    begin_frame();
    for (int v = 1; v <= 3; v++) alloc(v, 1'b0, 0, 0, 1'b0);
    merge(1, 3, 16); merge(2, 3, 16);
    finish_frame(3, 1'b0);

    // Duplicate merge is a no-op.
    begin_frame();
    for (int v = 1; v <= 2; v++) alloc(v, 1'b0, 0, 0, 1'b0);
    merge(1, 2, 16); merge(1, 2, 16);
    finish_frame(2, 1'b0);

    // Long chain 16->15->...->1, then a redundant merge burst that overfills the FIFO.
    begin_frame();
    for (int v = 1; v <= 16; v++) alloc(v, 1'b0, 0, 0, 1'b0);
    for (int k = 15; k >= 1; k--) merge(k, k + 1, 40);
    for (int j = 0; j < 10; j++) merge(15, 16, 0);
    chk("overflow_after_burst", int'(overflow), 1);
    finish_frame(16, 1'b1);

    for (int f = 0; f < 5; f++) random_frame();

    // Reset in the middle of a flatten.
    begin_frame();
    for (int v = 1; v <= 12; v++) alloc(v, 1'b0, 0, 0, 1'b0);
    cyc(1'b0, 0, 1'b0, 0, 0, 1'b1, 1'b1, 1'b0, 0);
    idle(4);
    chk("busy_mid_flatten", int'(busy), 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_max_label", int'(max_label), 0);
    chk("rst_mid_overflow", int'(overflow), 0);
    chk("rst_mid_resolve_done", int'(resolve_done), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) chk("no_resolve_after_rst", int'(resolve_done), 0);
    idle(6);
    chk("no_resolve_after_rst_late", int'(resolve_done), 0);

    for (int f = 0; f < 15; f++) random_frame();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
